spike_frame_sink: RTL and testbench
===================================

# spike_frame_sink

Parametrised network-output sink that turns each accepted fire vector from the network into a framed word stream. Each frame is a fire count followed by the indices of the outputs that fired. The block sits between the network core and the dispatch/host link. It replaces single-frame stack serialisation with two things: a priority-encoded scanner and an output FIFO, so the next network frame is accepted while earlier frames are still draining.

## Interface
- `NUM_OUT`, default 8: number of network outputs; must be ≥ 1.
- `FIFO_DEPTH`, default 16: output FIFO entries; power of two, ≥ 2.
- Derived `SNK_WIDTH = $clog2(NUM_OUT + 1)`: output word width.
- `clk`, input, 1: the single clock, rising edge.
- `arstn`, input, 1: asynchronous active-low reset.
- `net_valid`, input, 1: network output vector valid.
- `net_ready`, output, 1: sink can accept a vector.
- `net_out`, input, `NUM_OUT`: fire vector; bit i set means output i fired.
- `snk_ready`, input, 1: downstream accepts a word.
- `snk_valid`, output, 1: `snk` holds a valid word.
- `snk`, output, `SNK_WIDTH`: count or index word.
- `snk_last`, output, 1: marks the final word of a frame.

## Operation
- **Capture:** on `net_valid && net_ready`, latch `net_out` into the mask register. Latch popcount(`net_out`) into the count register. Enter HEADER.
- **FSM states:** IDLE, HEADER, SCAN.
- **IDLE:**
  - `net_ready` = 1; it is 0 in every other state.
  - On capture, go to HEADER.
- **HEADER:**
  - If the FIFO is not full, push {last = (count == 0), word = count}.
  - Then go to SCAN if count > 0, else IDLE.
  - If the FIFO is full, stall in HEADER.
- **SCAN:**
  - Each cycle with the FIFO not full, the priority encoder selects the highest set mask bit.
  - Push {last = (exactly one bit left), word = index}, then clear that bit.
  - Go to IDLE when the mask becomes zero. If the FIFO is full, stall with the mask unchanged.
- **Frame format:** the count word, then the indices in descending order; `snk_last` is set on the final word. An empty vector produces the single word 0 with `snk_last` = 1.
- **FIFO:**
  - `snk_valid` = !empty; `snk`/`snk_last` show the head entry.
  - Pop on `snk_valid && snk_ready`.
  - Push and pop in the same cycle is legal, including with the FIFO full-minus-one or empty.
  - A push is never attempted while the FIFO is full; there is no pass-through when full.
  - Occupancy counter width is `$clog2(FIFO_DEPTH + 1)`. Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Handshake rules:**
  - While `snk_valid && !snk_ready`, `snk` and `snk_last` hold stable.
  - The `net_out` value is sampled only at the accepting edge.
- **Reset:** asynchronous, clears the FSM to IDLE, the mask and count to 0, and the FIFO pointers and occupancy to 0. Outputs: `snk_valid` 0, `net_ready` 1, `snk` 0, `snk_last` 0. A reset mid-frame discards that frame and all FIFO contents.

## Timing
- Capture at edge C0; count pushed at C1; `snk_valid` rises in the cycle after C1.
- Frame with k fires and no backpressure:
  - indices pushed at edges C2 … C(k+1);
  - return to IDLE after C(k+1);
  - `net_ready` high again k+1 cycles after capture (one cycle after capture when k = 0).
- Sustained throughput: one word per cycle into the FIFO and one out.
- A new frame is accepted as soon as the FSM is IDLE, regardless of FIFO occupancy.
- `net_ready` is combinational from FSM state only, with no dependence on `net_valid`.

## Configuration
- `SNK_ASCENDING_EN` defined:
  - the priority encoder selects the lowest set bit, so indices are emitted in ascending order;
  - the count word stays first and `snk_last` stays on the final index.
- `SNK_ASCENDING_EN` undefined: indices are emitted in descending order (default).

## Test plan
- **Basic frame** (`NUM_OUT`=8, `FIFO_DEPTH`=4, `snk_ready`=1, `net_out`=8'b1010_0101):
  - `snk` sequence 4, 7, 5, 2, 0, with `snk_last` only on 0;
  - `net_ready` high again 5 cycles after capture.
- **Empty vector:** `net_out`=0 → single word 0 with `snk_last`=1; `net_ready` high one cycle after capture.
- **Backpressure:** `snk_ready`=0, `net_out`=8'hFF.
  - The FIFO fills with 8, 7, 6, 5; the FSM stalls in SCAN; `net_ready` stays 0.
  - Raise `snk_ready` → 8, 7, 6, 5, 4, 3, 2, 1, 0 in order, no loss or duplication, `snk_last` on 0.
- **Back-to-back frames:** frames 8'h03 then 8'h80 with `net_valid` held and `snk_ready` toggling every cycle.
  - The second frame is accepted the first cycle `net_ready` = 1 while the first is still in the FIFO.
  - Output is 2, 1, 0(last), 1, 7(last).
- **Reset mid-frame:** assert `arstn` low during SCAN of 8'hF0 with the FIFO partially full.
  - `snk_valid` drops immediately and `net_ready` = 1.
  - After release, frame 8'h01 yields exactly 1, 0(last).
- **Ascending order:** with `SNK_ASCENDING_EN` defined, `net_out`=8'b1010_0101 → 4, 0, 2, 5, 7(last).

Source files
------------

// File: rtl/spike_frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : spike_frame_sink
// Purpose  : Frames each accepted network fire vector as a count word followed
//            by the fired output indices, buffered in an output FIFO.
//            Define SNK_ASCENDING_EN to emit indices lowest-first.
// Revision : 1.0
// ============================================================================
module spike_frame_sink #(
   parameter  int NUM_OUT    = 8,
   parameter  int FIFO_DEPTH = 16,
   localparam int SNK_WIDTH  = $clog2(NUM_OUT + 1)
) (
   input  logic                 clk,
   input  logic                 arstn,
   input  logic                 net_valid,
   output logic                 net_ready,
   input  logic [NUM_OUT-1:0]   net_out,
   input  logic                 snk_ready,
   output logic                 snk_valid,
   output logic [SNK_WIDTH-1:0] snk,
   output logic                 snk_last
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t               r_state;
   logic [NUM_OUT-1:0]   r_mask;
   logic [SNK_WIDTH-1:0] r_count;

   logic [SNK_WIDTH:0]   r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_OCC_W-1:0]   r_occ;

   logic [SNK_WIDTH-1:0] w_popcnt;
   logic [SNK_WIDTH-1:0] w_sel_idx;
   logic [NUM_OUT-1:0]   w_sel_bit;
   logic [NUM_OUT-1:0]   w_mask_clr;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic [SNK_WIDTH:0]   w_push_data;

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         w_popcnt = w_popcnt + SNK_WIDTH'(net_out[i]);
      end
   end

   // Last match in loop order wins, which sets the encoder priority.
   always_comb begin
      w_sel_idx = '0;
      w_sel_bit = '0;
`ifdef SNK_ASCENDING_EN
      for (int i = NUM_OUT - 1; i >= 0; i--) begin
`else
      for (int i = 0; i < NUM_OUT; i++) begin
`endif
         if (r_mask[i]) begin
            w_sel_idx    = SNK_WIDTH'(i);
            w_sel_bit    = '0;
            w_sel_bit[i] = 1'b1;
         end
      end
   end

   assign w_mask_clr = r_mask & ~w_sel_bit;

   assign w_full  = (r_occ == c_OCC_W'(FIFO_DEPTH));
   assign w_empty = (r_occ == '0);
   assign w_push  = !w_full && ((r_state == ST_HEADER) || (r_state == ST_SCAN));
   assign w_pop   = !w_empty && snk_ready;

   assign w_push_data = (r_state == ST_HEADER) ? {(r_count == '0), r_count}
                                               : {(w_mask_clr == '0), w_sel_idx};

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_state <= ST_IDLE;
         r_mask  <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (net_valid) begin
                  r_mask  <= net_out;
                  r_count <= w_popcnt;
                  r_state <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (!w_full) begin
                  r_state <= (r_count != '0) ? ST_SCAN : ST_IDLE;
               end
            end
            ST_SCAN: begin
               if (!w_full) begin
                  r_mask <= w_mask_clr;
                  if (w_mask_clr == '0) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_occ <= r_occ + c_OCC_W'(w_push) - c_OCC_W'(w_pop);
      end
   end

   // Storage is not reset; the output mux hides stale entries while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   assign net_ready = (r_state == ST_IDLE);
   assign snk_valid = !w_empty;
   assign snk       = w_empty ? '0   : r_mem[r_rd_ptr][SNK_WIDTH-1:0];
   assign snk_last  = w_empty ? 1'b0 : r_mem[r_rd_ptr][SNK_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_spike_frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_frame_sink
// Purpose  : Directed and randomized checks of spike_frame_sink against a
//            frame-level reference queue.
// Revision : 1.0
// ============================================================================
module tb_spike_frame_sink;

   localparam int NUM_OUT    = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int SNK_WIDTH  = $clog2(NUM_OUT + 1);

   logic                 clk       = 1'b0;
   logic                 arstn     = 1'b0;
   logic                 net_valid = 1'b0;
   logic [NUM_OUT-1:0]   net_out   = '0;
   logic                 snk_ready = 1'b0;
   logic                 net_ready;
   logic                 snk_valid;
   logic [SNK_WIDTH-1:0] snk;
   logic                 snk_last;

   int n_checks = 0;
   int n_errors = 0;
   int n_caps   = 0;
   logic obs_ready;
   logic obs_valid;
   logic obs_valid_at_cap;
   logic [SNK_WIDTH:0] exp_q [$];

   spike_frame_sink #(
      .NUM_OUT    (NUM_OUT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_dut (
      .clk       (clk),
      .arstn     (arstn),
      .net_valid (net_valid),
      .net_ready (net_ready),
      .net_out   (net_out),
      .snk_ready (snk_ready),
      .snk_valid (snk_valid),
      .snk       (snk),
      .snk_last  (snk_last)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Frame = popcount word, then fired indices in emission order, last flag on the final word.
   function automatic void model_frame(input logic [NUM_OUT-1:0] vec);
      int order [$];
      int k;
      k = $countones(vec);
`ifdef SNK_ASCENDING_EN
      for (int i = 0; i < NUM_OUT; i++) if (vec[i]) order.push_back(i);
`else
      for (int i = NUM_OUT - 1; i >= 0; i--) if (vec[i]) order.push_back(i);
`endif
      exp_q.push_back({(k == 0), SNK_WIDTH'(k)});
      for (int j = 0; j < order.size(); j++) begin
         exp_q.push_back({(j == order.size() - 1), SNK_WIDTH'(order[j])});
      end
   endfunction

   // Called at a falling edge with inputs already set; evaluates just after it.
   task automatic cycle();
      #1;
      obs_ready = net_ready;
      obs_valid = snk_valid;
      if (snk_valid) begin
         if (exp_q.size() == 0) begin
            check_value("spurious_word", 32'(snk_valid), 32'd0);
         end else begin
            check_value("snk_word", 32'(snk), 32'(exp_q[0][SNK_WIDTH-1:0]));
            check_value("snk_last", 32'(snk_last), 32'(exp_q[0][SNK_WIDTH]));
            if (snk_ready) void'(exp_q.pop_front());
         end
      end
      if (net_valid && net_ready) begin
         model_frame(net_out);
         n_caps++;
         obs_valid_at_cap = snk_valid;
      end
      @(negedge clk);
   endtask

   task automatic capture(input logic [NUM_OUT-1:0] vec, input string tag);
      int c0;
      c0        = n_caps;
      net_valid = 1'b1;
      net_out   = vec;
      cycle();
      net_valid = 1'b0;
      net_out   = ~vec;
      check_value(tag, 32'(n_caps), 32'(c0 + 1));
   endtask

   task automatic wait_ready(input int k, input string tag, input bit chk_valid);
      int j;
      for (j = 0; j < 50; j++) begin
         cycle();
         if (chk_valid && j == 0) check_value("valid_after_c0", 32'(obs_valid), 32'd0);
         if (chk_valid && j == 1) check_value("valid_after_c1", 32'(obs_valid), 32'd1);
         if (obs_ready) break;
      end
      check_value(tag, 32'(j), 32'(k + 1));
   endtask

   task automatic drain();
      net_valid = 1'b0;
      snk_ready = 1'b1;
      for (int i = 0; i < 100 && (exp_q.size() != 0 || snk_valid); i++) cycle();
      check_value("drain_queue", 32'(exp_q.size()), 32'd0);
      check_value("drain_valid", 32'(snk_valid), 32'd0);
   endtask

   initial begin
      int c0;
      #1;
      check_value("rst_net_ready", 32'(net_ready), 32'd1);
      check_value("rst_snk_valid", 32'(snk_valid), 32'd0);
      check_value("rst_snk", 32'(snk), 32'd0);
      check_value("rst_snk_last", 32'(snk_last), 32'd0);
      @(negedge clk);
      arstn = 1'b1;
      @(negedge clk);

      snk_ready = 1'b1;
      capture(8'b1010_0101, "basic_capture");
      wait_ready(4, "basic_ready_latency", 1'b1);
      drain();

      capture(8'h00, "empty_capture");
      wait_ready(0, "empty_ready_latency", 1'b0);
      drain();

      snk_ready = 1'b0;
      capture(8'hFF, "bp_capture");
      repeat (10) cycle();
      check_value("bp_net_ready", 32'(net_ready), 32'd0);
      check_value("bp_head", 32'(snk), 32'd8);
      drain();

      c0        = n_caps;
      net_valid = 1'b1;
      net_out   = 8'h03;
      snk_ready = 1'b0;
      for (int i = 0; i < 40 && n_caps < c0 + 2; i++) begin
         cycle();
         if (n_caps == c0 + 1) net_out = 8'h80;
         snk_ready = ~snk_ready;
      end
      net_valid = 1'b0;
      check_value("b2b_captures", 32'(n_caps), 32'(c0 + 2));
      check_value("b2b_overlap", 32'(obs_valid_at_cap), 32'd1);
      drain();

      snk_ready = 1'b0;
      capture(8'hF0, "rst_mid_capture");
      repeat (3) cycle();
      check_value("rst_mid_pre_valid", 32'(snk_valid), 32'd1);
      #2 arstn = 1'b0;
      #1;
      check_value("rst_mid_valid", 32'(snk_valid), 32'd0);
      check_value("rst_mid_ready", 32'(net_ready), 32'd1);
      check_value("rst_mid_snk_last", 32'(snk_last), 32'd0);
      exp_q.delete();
      @(negedge clk);
      arstn     = 1'b1;
      snk_ready = 1'b1;
      capture(8'h01, "post_rst_capture");
      drain();

      for (int i = 0; i < 1500; i++) begin
         net_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 5))
            0:       net_out = '0;
            1:       net_out = '1;
            default: net_out = NUM_OUT'($urandom);
         endcase
         if (i < 500) snk_ready = ($urandom_range(0, 3) != 0);
         else         snk_ready = ($urandom_range(0, 3) == 0);
         cycle();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
